// File: rtl/result_accumulator_pkg.sv
// result_accumulator_pkg: FSM state type and batch-counter width helper
package result_accumulator_pkg;
  typedef enum logic {ACCUM, HOLD} state_e;
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrapping modulo-MAX counter with enable, sync clear and terminal-count flag
module mod_counter
  import result_accumulator_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);
  logic [W-1:0] count_q, count_d;
  assign count = count_q;
  assign tc = count_q == W'(MAX - 1);
  always_comb count_d = clear ? '0 : en ? (tc ? '0 : count_q + 1'b1) : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/result_accumulator.sv
// result_accumulator: sums COUNT accepted samples per batch and holds the result until taken
module result_accumulator
  import result_accumulator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = WIDTH + 8,
  parameter int COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);
  localparam int CW = cnt_width(COUNT);
  state_e state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
  logic out_valid_q, out_valid_d, accept, done, tc;
  logic [CW-1:0] cnt;
  assign in_ready = state_q == ACCUM;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign accept = in_valid && in_ready;
  assign done = accept && tc && cnt == CW'(COUNT - 1);
  assign sum = acc_q + ACC_WIDTH'(in_data);
  mod_counter #(.MAX(COUNT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .en(accept),
    .count(cnt),
    .tc(tc)
  );
  always_comb begin
    state_d = clear ? ACCUM : done ? HOLD : (state_q == HOLD && out_ready) ? ACCUM : state_q;
    acc_d = (clear || done) ? '0 : accept ? sum : acc_q;
    out_valid_d = clear ? 1'b0 : done ? 1'b1 : (state_q == HOLD && out_ready) ? 1'b0 : out_valid_q;
    out_data_d = (!clear && done) ? sum : out_data_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ACCUM;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
endmodule
